// File: rtl/lfu_repl_ctrl.sv
// LFU replacement controller: per-entry valid + saturating frequency counters,
// fills invalid entries first, then evicts the least frequently used entry.
module lfu_repl_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic             hit,
  input  logic             age,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_RST = (CNT_MAX >> 1) + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (age) begin
      // the saturating entry restarts just above the halved population
      if (hit)        cnt <= CNT_RST;
      else if (valid) cnt <= cnt >> 1;
    end else if (hit) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module lfu_repl_ctrl #(
  parameter int NUM_ENTRY = 4,
  parameter int CNT_W     = 2,
  parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_buf_req,
  input  logic             ref_vld,
  input  logic [IDX_W-1:0] ref_buf_numbr,
  output logic [IDX_W-1:0] buf_num_replc,
  output logic             repl_vld,
  output logic             age_evt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_ENTRY-1:0]            valid;
  logic [NUM_ENTRY-1:0][CNT_W-1:0] cnt;
  logic [NUM_ENTRY-1:0]            hit;
  logic [NUM_ENTRY-1:0]            fill;
  logic [NUM_ENTRY-1:0]            at_max;
  logic [IDX_W-1:0]                victim;
  logic                            age;

  // per-entry decode; an out-of-range index matches no entry and is dropped
  always_comb begin
    for (int i = 0; i < NUM_ENTRY; i++) begin
      hit[i]    = ref_vld && !new_buf_req && valid[i] && (ref_buf_numbr == IDX_W'(i));
      fill[i]   = new_buf_req && (victim == IDX_W'(i));
      at_max[i] = (cnt[i] == CNT_MAX);
    end
  end

  assign age = |(hit & at_max);

  always_comb begin
    logic             found_inv;
    logic [CNT_W-1:0] min_cnt;
    found_inv = 1'b0;
    victim    = '0;
    min_cnt   = CNT_MAX;
    for (int i = NUM_ENTRY-1; i >= 0; i--) begin
      if (!valid[i]) begin
        found_inv = 1'b1;
        victim    = IDX_W'(i);
      end
    end
    if (!found_inv) begin
      victim  = '0;
      min_cnt = cnt[0];
      for (int i = 1; i < NUM_ENTRY; i++) begin
        if (cnt[i] < min_cnt) begin
          min_cnt = cnt[i];
          victim  = IDX_W'(i);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_ent
    lfu_repl_entry #(.CNT_W(CNT_W)) u_ent (
      .clk   (clk),
      .rst_n (rst_n),
      .fill  (fill[g]),
      .hit   (hit[g]),
      .age   (age),
      .valid (valid[g]),
      .cnt   (cnt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_num_replc <= '0;
      repl_vld      <= 1'b0;
      age_evt       <= 1'b0;
    end else begin
      repl_vld <= new_buf_req;
      age_evt  <= age;
      if (new_buf_req) buf_num_replc <= victim;
    end
  end
endmodule

// File: tb/tb_lfu_repl_ctrl.sv
// Directed scenarios plus randomized traffic against an array-based LFU model.
module tb_lfu_repl_ctrl;
  localparam int NE    = 4;
  localparam int CW    = 2;
  localparam int IW    = 2;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          new_buf_req = 1'b0;
  logic          ref_vld = 1'b0;
  logic [IW-1:0] ref_buf_numbr = '0;
  logic [IW-1:0] buf_num_replc;
  logic          repl_vld;
  logic          age_evt;

  int n_chk = 0;
  int n_err = 0;

  int m_vld [NE];
  int m_cnt [NE];
  int e_idx, e_rv, e_age;

  always #5 clk = ~clk;

  lfu_repl_ctrl #(.NUM_ENTRY(NE), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .new_buf_req   (new_buf_req),
    .ref_vld       (ref_vld),
    .ref_buf_numbr (ref_buf_numbr),
    .buf_num_replc (buf_num_replc),
    .repl_vld      (repl_vld),
    .age_evt       (age_evt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick();
    int best;
    for (int i = 0; i < NE; i++) if (m_vld[i] == 0) return i;
    best = 0;
    for (int i = 1; i < NE; i++) if (m_cnt[i] < m_cnt[best]) best = i;
    return best;
  endfunction

  task automatic model(input bit rst, input bit req, input bit rv, input int rn);
    int v;
    e_rv  = 0;
    e_age = 0;
    if (rst) begin
      for (int i = 0; i < NE; i++) begin m_vld[i] = 0; m_cnt[i] = 0; end
      e_idx = 0;
    end else if (req) begin
      v = pick();
      e_idx = v; e_rv = 1;
      m_vld[v] = 1; m_cnt[v] = 1;
    end else if (rv && rn < NE && m_vld[rn] == 1) begin
      if (m_cnt[rn] < CMAX) m_cnt[rn]++;
      else begin
        for (int i = 0; i < NE; i++) if (m_vld[i] == 1) m_cnt[i] = m_cnt[i] / 2;
        m_cnt[rn] = CMAX / 2 + 1;
        e_age = 1;
      end
    end
  endtask

  // one clock: apply inputs, advance model, compare registered outputs after the edge
  task automatic cyc(input bit rst, input bit req, input bit rv, input int rn);
    rst_n         = !rst;
    new_buf_req   = req;
    ref_vld       = rv;
    ref_buf_numbr = IW'(rn);
    model(rst, req, rv, rn);
    @(posedge clk);
    #1;
    chk("idx", int'(buf_num_replc), e_idx);
    chk("repl_vld", int'(repl_vld), e_rv);
    chk("age_evt", int'(age_evt), e_age);
  endtask

  task automatic fill4();
    for (int i = 0; i < NE; i++) cyc(0, 1, 0, 0);
  endtask

  initial begin
    int exp_t1 [5];
    exp_t1 = '{0, 1, 2, 3, 0};
    @(posedge clk); #1;
    cyc(1, 1, 1, 2);
    chk("rst_idx", int'(buf_num_replc), 0);
    chk("rst_vld", int'(repl_vld), 0);

    // T1 fill order and tie-break
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0);
      chk("t1_idx", int'(buf_num_replc), exp_t1[i]);
      chk("t1_vld", int'(repl_vld), 1);
    end
    cyc(0, 0, 0, 0);
    chk("t1_hold", int'(buf_num_replc), 0);
    chk("t1_pulse", int'(repl_vld), 0);

    // T2 LFU pick
    cyc(1, 0, 0, 0); fill4();
    cyc(0, 0, 1, 2); cyc(0, 0, 1, 2); cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    chk("t2_idx", int'(buf_num_replc), 1);

    // T6 mid-op reset, discarding a same-cycle request
    cyc(1, 1, 0, 0);
    chk("t6_vld", int'(repl_vld), 0);
    chk("t6_idx", int'(buf_num_replc), 0);
    cyc(0, 1, 0, 0);
    chk("t6_next", int'(buf_num_replc), 0);

    // T3 aging
    cyc(1, 0, 0, 0); fill4();
    cyc(0, 0, 1, 3); cyc(0, 0, 1, 3);
    chk("t3_noage", int'(age_evt), 0);
    cyc(0, 0, 1, 3);
    chk("t3_age", int'(age_evt), 1);
    cyc(0, 0, 0, 0);
    chk("t3_pulse", int'(age_evt), 0);
    cyc(0, 1, 0, 0);
    chk("t3_idx", int'(buf_num_replc), 0);

    // T4 collision: request wins
    cyc(1, 0, 0, 0); fill4();
    cyc(0, 1, 1, 1);
    chk("t4_idx", int'(buf_num_replc), 0);
    cyc(0, 1, 0, 0);
    chk("t4_next", int'(buf_num_replc), 0);

    // T5 reference to invalid entry
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 2);
    chk("t5_noage", int'(age_evt), 0);
    cyc(0, 1, 0, 0);
    chk("t5_idx", int'(buf_num_replc), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 70), int'($urandom_range(0, NE-1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
